// File: rtl/sdram_page_scheduler_if.sv
// Operation handshake between the page scheduler and the SDRAM command engine.
// The scheduler (master) presents one operation at a time; the engine (slave)
// acknowledges it with op_ack and reports completion with op_done.
interface sdram_page_scheduler_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [1:0]  op_bank;
  logic [12:0] op_row;
  logic        op_ack;
  logic        op_done;

  modport master (
    output op_valid,
    output op_code,
    output op_bank,
    output op_row,
    input  op_ack,
    input  op_done
  );

  modport slave (
    input  op_valid,
    input  op_code,
    input  op_bank,
    input  op_row,
    output op_ack,
    output op_done
  );
endinterface

// File: rtl/sdram_page_scheduler.sv
// Page-granular SDRAM scheduler: arbitrates between the USB FIFO writer, the
// page reader and auto-refresh, keeps the SDRAM as a ring buffer of full pages
// and hands one operation at a time to the SDRAM command engine.
// Optional build macro SDRAM_SCHED_STATS_EN adds completion/forced-refresh
// statistics counters; scheduling behaviour is identical either way.
module sdram_page_scheduler #(
  parameter int PTR_W        = 15,
  parameter int REF_INTERVAL = 374,
  parameter int REF_MAX      = 8,
  parameter int STARVE_LIM   = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  sdram_rfo,
  input  logic                  wr_page_rdy,
  input  logic                  rd_page_rdy,
  sdram_page_scheduler_if.master bus,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W:0]        level,
  output logic                  ref_overdue
`ifdef SDRAM_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_wr_pages,
  output logic [31:0]           stat_rd_pages,
  output logic [15:0]           stat_ref_forced
`endif
);

  localparam int CRED_W = $clog2(REF_MAX + 1);
  localparam int TMR_W  = $clog2(REF_INTERVAL);
  localparam int STRK_W = $clog2(STARVE_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_READ    = 2'b10,
    OP_REFRESH = 2'b11
  } op_t;

  state_t              state;
  op_t                 cur_op;
  logic [PTR_W:0]      wr_ptr;
  logic [PTR_W:0]      rd_ptr;
  logic [CRED_W-1:0]   credits;
  logic [TMR_W-1:0]    timer;
  logic [STRK_W-1:0]   streak;

  op_t                 pick_op;
  logic [1:0]          pick_bank;
  logic [12:0]         pick_row;

  logic                rd_eligible;
  logic                starved;
  logic                ref_forced;
  logic                ref_tick;
  logic                complete;
  logic                ref_done;

  // Fill-level view of the ring: the MSB of each pointer is a wrap flag, so
  // equal pointers mean empty and equal low bits with differing MSBs mean full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign rd_eligible = rd_page_rdy && !empty;
  assign starved     = (streak >= STRK_W'(STARVE_LIM)) && rd_eligible;
  assign ref_forced  = (credits == CRED_W'(REF_MAX));
  assign ref_overdue = ref_forced;
  assign ref_tick    = sdram_rfo && (timer == TMR_W'(REF_INTERVAL - 1));

  // An operation only completes while the SDRAM is still usable; a done pulse
  // that races with sdram_rfo dropping belongs to an abandoned operation.
  assign complete = (state == ST_BUSY) && bus.op_done && sdram_rfo;
  assign ref_done = complete && (cur_op == OP_REFRESH);

  // Priority decision made in IDLE: overdue refresh, write (unless it would
  // starve an eligible read), read, then opportunistic refresh.
  always_comb begin
    pick_op   = OP_NONE;
    pick_bank = 2'b00;
    pick_row  = 13'd0;
    if (ref_forced) begin
      pick_op = OP_REFRESH;
    end else if (wr_page_rdy && !full && !starved) begin
      pick_op   = OP_WRITE;
      pick_bank = wr_ptr[PTR_W-1 -: 2];
      pick_row  = 13'(wr_ptr[PTR_W-3:0]);
    end else if (rd_eligible) begin
      pick_op   = OP_READ;
      pick_bank = rd_ptr[PTR_W-1 -: 2];
      pick_row  = 13'(rd_ptr[PTR_W-3:0]);
    end else if (credits != '0) begin
      pick_op = OP_REFRESH;
    end
  end

  // Operation FSM: registers the chosen request in IDLE, holds it until the
  // engine acknowledges, then waits for completion.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= ST_IDLE;
      cur_op       <= OP_NONE;
      bus.op_valid <= 1'b0;
      bus.op_code  <= OP_NONE;
      bus.op_bank  <= 2'b00;
      bus.op_row   <= 13'd0;
    end else if (!sdram_rfo) begin
      state        <= ST_IDLE;
      cur_op       <= OP_NONE;
      bus.op_valid <= 1'b0;
      bus.op_code  <= OP_NONE;
      bus.op_bank  <= 2'b00;
      bus.op_row   <= 13'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_op != OP_NONE) begin
            state        <= ST_ISSUE;
            cur_op       <= pick_op;
            bus.op_valid <= 1'b1;
            bus.op_code  <= pick_op;
            bus.op_bank  <= pick_bank;
            bus.op_row   <= pick_row;
          end
        end
        ST_ISSUE: begin
          if (bus.op_ack) begin
            state        <= ST_BUSY;
            bus.op_valid <= 1'b0;
            bus.op_code  <= OP_NONE;
            bus.op_bank  <= 2'b00;
            bus.op_row   <= 13'd0;
          end
        end
        ST_BUSY: begin
          if (bus.op_done) begin
            state  <= ST_IDLE;
            cur_op <= OP_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Ring pointers and write streak advance only when an operation completes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      streak <= '0;
    end else if (complete) begin
      if (cur_op == OP_WRITE) begin
        wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
        if (streak != STRK_W'(STARVE_LIM)) begin
          streak <= streak + STRK_W'(1);
        end
      end else if (cur_op == OP_READ) begin
        rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        streak <= '0;
      end
    end
  end

  // Refresh credit bookkeeping: timer runs only while the SDRAM is ready; a
  // credit earned in the same cycle one is spent leaves the count unchanged.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      credits <= '0;
    end else if (!sdram_rfo) begin
      timer   <= '0;
      credits <= '0;
    end else begin
      if (ref_tick) begin
        timer <= '0;
      end else begin
        timer <= timer + TMR_W'(1);
      end
      if (ref_tick && !ref_done) begin
        if (!ref_forced) begin
          credits <= credits + CRED_W'(1);
        end
      end else if (!ref_tick && ref_done) begin
        if (credits != '0) begin
          credits <= credits - CRED_W'(1);
        end
      end
    end
  end

`ifdef SDRAM_SCHED_STATS_EN
  // Free-running statistics: completed writes, completed reads and refreshes
  // issued because credits had reached the mandatory limit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_wr_pages   <= 32'd0;
      stat_rd_pages   <= 32'd0;
      stat_ref_forced <= 16'd0;
    end else begin
      if (complete && (cur_op == OP_WRITE)) begin
        stat_wr_pages <= stat_wr_pages + 32'd1;
      end
      if (complete && (cur_op == OP_READ)) begin
        stat_rd_pages <= stat_rd_pages + 32'd1;
      end
      if (sdram_rfo && (state == ST_IDLE) && ref_forced) begin
        stat_ref_forced <= stat_ref_forced + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sdram_page_scheduler.sv
// Scoreboard bench for sdram_page_scheduler with an 8-page ring (PTR_W=3),
// so bank = page[2:1] and row = page[0]. Expected operations are queued by the
// stimulus; a monitor pops and compares each operation the engine accepts.
module tb_sdram_page_scheduler;
  localparam int PTR_W = 3;

  logic           clk = 1'b0;
  logic           n_rst;
  logic           sdram_rfo;
  logic           wr_page_rdy;
  logic           rd_page_rdy;
  logic           full;
  logic           empty;
  logic [PTR_W:0] level;
  logic           ref_overdue;
`ifdef SDRAM_SCHED_STATS_EN
  logic [31:0]    stat_wr_pages;
  logic [31:0]    stat_rd_pages;
  logic [15:0]    stat_ref_forced;
`endif

  sdram_page_scheduler_if bus();

  sdram_page_scheduler #(
    .PTR_W(PTR_W),
    .REF_INTERVAL(374),
    .REF_MAX(8),
    .STARVE_LIM(4)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .sdram_rfo(sdram_rfo),
    .wr_page_rdy(wr_page_rdy),
    .rd_page_rdy(rd_page_rdy),
    .bus(bus),
    .full(full),
    .empty(empty),
    .level(level),
    .ref_overdue(ref_overdue)
`ifdef SDRAM_SCHED_STATS_EN
    ,
    .stat_wr_pages(stat_wr_pages),
    .stat_rd_pages(stat_rd_pages),
    .stat_ref_forced(stat_ref_forced)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  code;
    logic [1:0]  bank;
    logic [12:0] row;
  } op_rec_t;

  op_rec_t sb[$];
  int      total = 0;
  int      bad = 0;
  int      ops_seen = 0;
  int      done_seen = 0;
  int      exp_ops = 0;
  int      cyc = 0;
  logic    engine_hold = 1'b0;

  // Cycle counter used for refresh-timing windows.
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: acknowledges any presented op, then reports done two
  // cycles later unless held.
  initial begin
    bus.op_ack  = 1'b0;
    bus.op_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.op_valid) begin
        bus.op_ack = 1'b1;
        @(negedge clk);
        bus.op_ack = 1'b0;
        repeat (2) @(negedge clk);
        while (engine_hold) @(negedge clk);
        bus.op_done = 1'b1;
        done_seen++;
        @(negedge clk);
        bus.op_done = 1'b0;
      end
    end
  end

  // Monitor: every accepted operation is checked against the scoreboard.
  initial begin
    op_rec_t got;
    op_rec_t want;
    forever begin
      @(negedge clk);
      #1;
      if (n_rst && bus.op_valid && bus.op_ack) begin
        got = {bus.op_code, bus.op_bank, bus.op_row};
        ops_seen++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_op: got code=%0d bank=%0d row=%0d, required none", got.code, got.bank, got.row);
        end else begin
          want = sb.pop_front();
          if (got !== want) begin
            bad++;
            $display("[TB] FAIL op_%0d: got code=%0d bank=%0d row=%0d, required code=%0d bank=%0d row=%0d",
                     ops_seen, got.code, got.bank, got.row, want.code, want.bank, want.row);
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rfo, input logic wr, input logic rd);
    sdram_rfo   = rfo;
    wr_page_rdy = wr;
    rd_page_rdy = rd;
  endtask

  task automatic expectRw(input logic [1:0] code, input int page);
    logic [1:0]  b;
    logic [12:0] r;
    b = 2'((page >> 1) & 3);
    r = 13'(page & 1);
    sb.push_back({code, b, r});
    exp_ops++;
  endtask

  task automatic expectRef(input int n);
    repeat (n) begin
      sb.push_back({2'b11, 2'b00, 13'd0});
      exp_ops++;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic waitOps(input int target, input int budget, input string name);
    int n = 0;
    while (ops_seen < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    total++;
    if (ops_seen < target) begin
      bad++;
      $display("[TB] FAIL timeout_%s: got %0d ops, required %0d", name, ops_seen, target);
    end
  endtask

  task automatic waitDone(input int budget, input string name);
    int n = 0;
    while (done_seen < ops_seen && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    total++;
    if (done_seen < ops_seen) begin
      bad++;
      $display("[TB] FAIL timeout_%s: got %0d dones, required %0d", name, done_seen, ops_seen);
    end
    waitCycles(3);
  endtask

  // Directed scenario sequence.
  initial begin
    int t0;
    n_rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("rst_op_valid", 32'(bus.op_valid), 0);
    checkOutput("rst_op_code", 32'(bus.op_code), 0);
    checkOutput("rst_empty", 32'(empty), 1);
    checkOutput("rst_full", 32'(full), 0);
    checkOutput("rst_level", 32'(level), 0);
    checkOutput("rst_overdue", 32'(ref_overdue), 0);
    n_rst = 1'b1;
    waitCycles(2);

    $display("[TB] first refresh after one interval");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(370);
    checkOutput("no_early_refresh", 32'(bus.op_valid), 0);
    expectRef(1);
    waitOps(exp_ops, 30, "first_refresh");
    waitDone(20, "first_refresh_done");
    checkOutput("p1_level", 32'(level), 0);
    checkOutput("p1_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] three page writes");
    expectRw(2'b01, 0);
    expectRw(2'b01, 1);
    expectRw(2'b01, 2);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitOps(exp_ops, 60, "writes");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20, "writes_done");
    checkOutput("p2_level", 32'(level), 3);
    checkOutput("p2_empty", 32'(empty), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] three page reads");
    expectRw(2'b10, 0);
    expectRw(2'b10, 1);
    expectRw(2'b10, 2);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitOps(exp_ops, 60, "reads");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20, "reads_done");
    checkOutput("p3_level", 32'(level), 0);
    checkOutput("p3_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] write streak limit with both sides ready");
    expectRw(2'b01, 3);
    expectRw(2'b01, 4);
    expectRw(2'b01, 5);
    expectRw(2'b01, 6);
    expectRw(2'b10, 3);
    expectRw(2'b01, 7);
    expectRw(2'b01, 0);
    expectRw(2'b01, 1);
    expectRw(2'b01, 2);
    expectRw(2'b10, 4);
    applyStimulus(1'b1, 1'b1, 1'b1);
    waitOps(exp_ops, 150, "streak");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20, "streak_done");
    checkOutput("p4_level", 32'(level), 6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] stalled engine drives refresh overdue");
    engine_hold = 1'b1;
    expectRw(2'b01, 3);
    applyStimulus(1'b1, 1'b1, 1'b0);
    t0 = cyc;
    waitOps(exp_ops, 20, "stall_write");
    while (cyc - t0 < 2900) @(negedge clk);
    #2;
    checkOutput("overdue_at_7", 32'(ref_overdue), 0);
    while (!ref_overdue && cyc - t0 < 3100) @(negedge clk);
    #2;
    checkOutput("overdue_at_8", 32'(ref_overdue), 1);
    expectRef(1);
    expectRw(2'b01, 4);
    expectRef(7);
    engine_hold = 1'b0;
    waitOps(exp_ops, 300, "overdue_drain");
    waitDone(20, "overdue_drain_done");
    checkOutput("p5_full", 32'(full), 1);
    checkOutput("p5_level", 32'(level), 8);
    checkOutput("p5_overdue", 32'(ref_overdue), 0);
    waitCycles(30);
    checkOutput("no_write_when_full", 32'(bus.op_valid), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] read frees a page, write wraps");
    expectRw(2'b10, 5);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitOps(exp_ops, 20, "free_read");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20, "free_read_done");
    checkOutput("p6_full_after_read", 32'(full), 0);
    checkOutput("p6_level_after_read", 32'(level), 7);
    expectRw(2'b01, 5);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitOps(exp_ops, 20, "wrap_write");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitDone(20, "wrap_write_done");
    checkOutput("p6_full", 32'(full), 1);
    checkOutput("p6_level", 32'(level), 8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] rfo dropped while busy");
    engine_hold = 1'b1;
    expectRw(2'b10, 6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitOps(exp_ops, 20, "abort_read");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(400);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(3);
    checkOutput("abort_op_valid", 32'(bus.op_valid), 0);
    checkOutput("abort_level", 32'(level), 8);
    checkOutput("abort_full", 32'(full), 1);
    engine_hold = 1'b0;
    waitDone(20, "late_done");
    checkOutput("late_done_level", 32'(level), 8);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(370);
    checkOutput("credits_cleared", 32'(bus.op_valid), 0);
    expectRef(1);
    waitOps(exp_ops, 30, "refresh_after_abort");
    waitDone(20, "refresh_after_abort_done");
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    $display("[TB] reset mid-operation");
    engine_hold = 1'b1;
    expectRw(2'b10, 6);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitOps(exp_ops, 20, "reset_read");
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitCycles(5);
    n_rst = 1'b0;
    waitCycles(2);
    checkOutput("midrst_level", 32'(level), 0);
    checkOutput("midrst_empty", 32'(empty), 1);
    checkOutput("midrst_op_valid", 32'(bus.op_valid), 0);
    n_rst = 1'b1;
    engine_hold = 1'b0;
    waitDone(20, "reset_late_done");
    checkOutput("postrst_level", 32'(level), 0);
    checkOutput("postrst_empty", 32'(empty), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(2);

    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
